// File: rtl/axis_output_pipe_pkg.sv
// Shared sizing defaults and state encoding for the conv-engine output pipe.
`ifndef UNITS
`define UNITS 8
`endif
`ifndef CORES
`define CORES 4
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 8
`endif
`ifndef M_WORDS
`define M_WORDS 8
`endif

package axis_output_pipe_pkg;

  localparam int unsigned DEF_UNITS      = `UNITS;
  localparam int unsigned DEF_CORES      = `CORES;
  localparam int unsigned DEF_WORD_WIDTH = `WORD_WIDTH;
  localparam int unsigned DEF_M_WORDS    = `M_WORDS;

  // IDLE: nothing held; SEND: a conv beat is held and being sliced out
  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } pipe_state_t;

endpackage

// File: rtl/axis_output_pipe.sv
// Holds one wide conv-engine beat and replays it as R narrow DMA beats,
// slice 0 first, reloading on the final slice handshake without a bubble.
module axis_output_pipe
    import axis_output_pipe_pkg::*;
#(
    parameter int unsigned UNITS      = DEF_UNITS,
    parameter int unsigned CORES      = DEF_CORES,
    parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int unsigned M_WORDS    = DEF_M_WORDS
) (
    input  logic                                aclk,
    input  logic                                areset,
    output logic                                s_axis_tready,
    input  logic                                s_axis_tvalid,
    input  logic                                s_axis_tlast,
    input  logic [WORD_WIDTH*CORES*UNITS-1:0]   s_axis_tdata,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tvalid,
    output logic                                m_axis_tlast,
    output logic [WORD_WIDTH*M_WORDS-1:0]       m_axis_tdata,
    output logic [WORD_WIDTH*M_WORDS/8-1:0]     m_axis_tkeep
);

    localparam int unsigned R       = CORES * UNITS / M_WORDS;
    localparam int unsigned CNT_W   = $clog2(R);
    localparam int unsigned SLICE_W = WORD_WIDTH * M_WORDS;
    localparam int unsigned IN_W    = WORD_WIDTH * CORES * UNITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(R - 1);

    pipe_state_t      state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [IN_W-1:0]  hold_data, hold_data_nx;
    logic             hold_last, hold_last_nx;
    logic             ready_en;
    logic             on_last;
    logic             accept;
    logic             out_hs;

    assign on_last       = (cnt == CNT_LAST);
    // valid comes straight from state so it never depends on m_axis_tready
    assign m_axis_tvalid = (state == ST_SEND);
    assign out_hs        = m_axis_tvalid && m_axis_tready;
    // ready_en keeps the input closed during reset and for the first cycle after
    assign s_axis_tready = ready_en && ((state == ST_IDLE) || (on_last && m_axis_tready));
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign m_axis_tlast  = m_axis_tvalid && on_last && hold_last;
    assign m_axis_tkeep  = m_axis_tvalid ? '1 : '0;

    // State, slice counter and holding register update
    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            hold_data <= '0;
            hold_last <= 1'b0;
            ready_en  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            hold_data <= hold_data_nx;
            hold_last <= hold_last_nx;
            ready_en  <= 1'b1;
        end
    end

    // Next-state: load on accept, step slices on handshake, reload or idle after the last
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        hold_data_nx = hold_data;
        hold_last_nx = hold_last;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx     = ST_SEND;
                    cnt_nx       = '0;
                    hold_data_nx = s_axis_tdata;
                    hold_last_nx = s_axis_tlast;
                end
            end
            ST_SEND: begin
                if (out_hs) begin
                    if (!on_last) begin
                        cnt_nx = cnt + 1'b1;
                    end else if (accept) begin
                        cnt_nx       = '0;
                        hold_data_nx = s_axis_tdata;
                        hold_last_nx = s_axis_tlast;
                    end else begin
                        state_nx = ST_IDLE;
                        cnt_nx   = '0;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Slice select: words cnt*M_WORDS .. cnt*M_WORDS+M_WORDS-1 of the held beat
    always_comb begin
        m_axis_tdata = '0;
        for (int unsigned i = 0; i < R; i++) begin
            if (cnt == CNT_W'(i)) begin
                m_axis_tdata = hold_data[i*SLICE_W +: SLICE_W];
            end
        end
    end

endmodule

// File: tb/tb_axis_output_pipe.sv
// Directed and randomized bench for axis_output_pipe against a queue-based slice model.
module tb_axis_output_pipe;

    localparam int unsigned UNITS  = 8;
    localparam int unsigned CORES  = 4;
    localparam int unsigned WW     = 8;
    localparam int unsigned MW     = 8;
    localparam int unsigned R      = CORES * UNITS / MW;
    localparam int unsigned IN_W   = WW * CORES * UNITS;
    localparam int unsigned OUT_W  = WW * MW;
    localparam int unsigned KEEP_W = OUT_W / 8;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic              s_axis_tready;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tlast = 1'b0;
    logic [IN_W-1:0]   s_axis_tdata = '0;
    logic              m_axis_tready = 1'b0;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic [OUT_W-1:0]  m_axis_tdata;
    logic [KEEP_W-1:0] m_axis_tkeep;

    always #5 aclk = ~aclk;

    axis_output_pipe #(
        .UNITS      (UNITS),
        .CORES      (CORES),
        .WORD_WIDTH (WW),
        .M_WORDS    (MW)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tready (s_axis_tready),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tready (m_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep)
    );

    typedef struct packed {
        logic [OUT_W-1:0] d;
        logic             l;
    } slice_t;

    // Model: slices still owed downstream, oldest first
    slice_t exp_q[$];
    bit     ready_model = 1'b0;
    bit     check_en = 1'b0;
    bit     accepted = 1'b0;
    int     checks = 0;
    int     errors = 0;
    int     in_last_cnt = 0;
    int     out_last_cnt = 0;

    task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs mid-cycle, then advance the model at the rising edge
    task automatic cycle();
        bit               exp_ready;
        bit               acc;
        bit               hs;
        logic [KEEP_W-1:0] exp_keep;
        @(negedge aclk);
        if (check_en) begin
            exp_ready = ready_model && (exp_q.size() == 0 || (exp_q.size() == 1 && m_axis_tready));
            exp_keep  = (exp_q.size() != 0) ? {KEEP_W{1'b1}} : {KEEP_W{1'b0}};
            check("m_tvalid", OUT_W'(m_axis_tvalid), OUT_W'(exp_q.size() != 0));
            check("m_tkeep", OUT_W'(m_axis_tkeep), OUT_W'(exp_keep));
            check("s_tready", OUT_W'(s_axis_tready), OUT_W'(exp_ready));
            check("m_tlast", OUT_W'(m_axis_tlast), OUT_W'((exp_q.size() != 0) ? exp_q[0].l : 1'b0));
            if (exp_q.size() != 0)
                check("m_tdata", m_axis_tdata, exp_q[0].d);
        end
        acc = s_axis_tvalid && s_axis_tready;
        hs  = m_axis_tvalid && m_axis_tready;
        @(posedge aclk);
        if (areset) begin
            exp_q.delete();
            ready_model = 1'b0;
            accepted = 1'b0;
        end else begin
            if (hs && m_axis_tlast) out_last_cnt++;
            if (hs && exp_q.size() != 0) void'(exp_q.pop_front());
            if (acc) begin
                for (int unsigned i = 0; i < R; i++)
                    exp_q.push_back('{d: s_axis_tdata[i*OUT_W +: OUT_W], l: s_axis_tlast && (i == R - 1)});
                if (s_axis_tlast) in_last_cnt++;
            end
            ready_model = 1'b1;
            accepted = acc;
        end
        #1;
    endtask

    task automatic ramp_data();
        for (int k = 0; k < int'(CORES * UNITS); k++) s_axis_tdata[k*WW +: WW] = WW'(k);
    endtask

    task automatic rand_data();
        for (int k = 0; k < int'(IN_W / 32); k++) s_axis_tdata[k*32 +: 32] = $urandom;
    endtask

    initial begin
        int n;
        int budget;
        logic [3:0] pat;

        // Reset: first edge unchecked (outputs undefined before it), then reset values
        areset = 1'b1;
        cycle();
        check_en = 1'b1;
        cycle();
        areset = 1'b0;
        cycle();          // s_tready still low in the cycle right after reset drops
        cycle();          // and high from here on

        // Single beat with word k = k, tlast set, downstream always ready
        ramp_data();
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        cycle();
        check("single_accept", OUT_W'(accepted), OUT_W'(1));
        s_axis_tvalid = 1'b0;
        check("slice0_words", m_axis_tdata, 64'h0706050403020100);
        repeat (6) cycle();

        // Back-to-back: three beats presented with tvalid held high
        n = 0;
        budget = 0;
        rand_data();
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        while (n < 3 && budget < 40) begin
            cycle();
            budget++;
            if (accepted) begin
                n++;
                rand_data();
                s_axis_tlast = (n == 2);
                if (n == 3) s_axis_tvalid = 1'b0;
            end
        end
        check("b2b_accepts", OUT_W'(n), OUT_W'(3));
        s_axis_tvalid = 1'b0;
        repeat (4) cycle();

        // Backpressure: downstream ready toggles 1,0,0,1,...
        ramp_data();
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        pat = 4'b1001;
        for (int i = 0; i < 20; i++) begin
            m_axis_tready = pat[i % 4];
            cycle();
            if (accepted) s_axis_tvalid = 1'b0;
        end
        m_axis_tready = 1'b1;
        repeat (2) cycle();

        // Reset after slice 1 has gone out: remaining slices are dropped
        rand_data();
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        cycle();
        s_axis_tvalid = 1'b0;
        cycle();          // slice 0
        cycle();          // slice 1
        areset = 1'b1;
        cycle();
        areset = 1'b0;
        cycle();          // tvalid low, s_tready low
        cycle();          // s_tready back high
        ramp_data();
        s_axis_tvalid = 1'b1;
        cycle();
        s_axis_tvalid = 1'b0;
        check("post_reset_slice0", m_axis_tdata, 64'h0706050403020100);
        repeat (5) cycle();

        // Idle: nothing offered for 10 cycles
        for (int i = 0; i < 10; i++) begin
            m_axis_tready = 1'(i % 2);
            cycle();
        end

        // Random traffic: 1000 beats, random valid/ready, holding data while valid
        in_last_cnt  = 0;
        out_last_cnt = 0;
        n = 0;
        budget = 0;
        accepted = 1'b0;
        while (n < 1000 && budget < 20000) begin
            if (accepted || !s_axis_tvalid) begin
                if ($urandom_range(3) != 0) begin
                    rand_data();
                    s_axis_tlast  = 1'($urandom_range(1));
                    s_axis_tvalid = 1'b1;
                end else begin
                    s_axis_tvalid = 1'b0;
                end
            end
            m_axis_tready = ($urandom_range(3) != 0);
            cycle();
            budget++;
            if (accepted) n++;
        end
        check("random_accepts", OUT_W'(n), OUT_W'(1000));
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            cycle();
            budget++;
        end
        cycle();
        check("drain_done", OUT_W'(m_axis_tvalid), OUT_W'(0));
        check("tlast_count", OUT_W'(out_last_cnt), OUT_W'(in_last_cnt));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_output_pipe.md
AXIS_OUTPUT_PIPE -- requirements
Module: axis_output_pipe

Interface
- REQ-001 SHALL have parameter UNITS, default `UNITS (8): rows per core in one conv-engine output beat.
- REQ-002 SHALL have parameter CORES, default `CORES (4): cores per conv-engine output beat.
- REQ-003 SHALL have parameter WORD_WIDTH, default `WORD_WIDTH (8): bits per word.
- REQ-004 SHALL have parameter M_WORDS, default 8: words per output (DMA) beat. R = CORES*UNITS/M_WORDS SHALL be an integer power of two, ≥2.
- REQ-005 SHALL have port aclk, input, 1: the single clock; all logic on its rising edge.
- REQ-006 SHALL have port areset, input, 1: synchronous, active-high reset.
- REQ-007 SHALL have port s_axis_tready, output, 1: the block accepts a conv beat.
- REQ-008 SHALL have port s_axis_tvalid, input, 1: conv beat valid.
- REQ-009 SHALL have port s_axis_tlast, input, 1: last conv beat of the packet.
- REQ-010 SHALL have port s_axis_tdata, input, WORD_WIDTH*CORES*UNITS: conv beat, word k at bits [k*WORD_WIDTH +: WORD_WIDTH].
- REQ-011 SHALL have port m_axis_tready, input, 1: downstream accepts.
- REQ-012 SHALL have port m_axis_tvalid, output, 1: output beat valid.
- REQ-013 SHALL have port m_axis_tlast, output, 1: last output beat of the packet.
- REQ-014 SHALL have port m_axis_tdata, output, WORD_WIDTH*M_WORDS: output slice.
- REQ-015 SHALL have port m_axis_tkeep, output, WORD_WIDTH*M_WORDS/8: byte enables.

Function
- REQ-016 SHALL accept a conv beat on s_axis_tvalid && s_axis_tready, latching tdata and tlast into a holding register.
- REQ-017 SHALL emit each held beat as R output beats, slice 0 (words 0..M_WORDS-1) first, ascending.
- REQ-018 SHALL run an FSM with two states: IDLE (nothing held) and SEND (beat held, slice counter cnt in 0..R-1).
- REQ-019 SHALL move IDLE->SEND on accept, with cnt=0 and m_axis_tvalid=1 in the next cycle. Latency from accept to first output beat is 1 cycle.
- REQ-020 SHALL increment cnt in SEND on m_axis_tvalid && m_axis_tready when cnt<R-1, and SHALL hold tdata and tlast stable otherwise.
- REQ-021 SHALL set s_axis_tready = (state==IDLE) || (cnt==R-1 && m_axis_tready).
- REQ-022 SHALL handle handshake of slice R-1 with a simultaneous new accept by reloading the holding register and going to SEND with cnt=0, leaving no bubble. Without a new accept, it SHALL go to IDLE.
- REQ-023 SHALL assert m_axis_tlast only on slice R-1 of a beat accepted with s_axis_tlast=1.
- REQ-024 SHALL drive m_axis_tkeep all-ones whenever m_axis_tvalid=1, and all-zeros otherwise.
- REQ-025 SHALL never let m_axis_tvalid drop in SEND before handshake, and SHALL not let m_axis_tvalid depend combinationally on m_axis_tready.
- REQ-026 SHALL make cnt $clog2(R) bits wide and wrap R-1 to 0 only on the reload described in REQ-022.

Reset
- REQ-027 SHALL apply these values while areset is high at a clock edge: state=IDLE, cnt=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, s_axis_tready=0, holding data=0.
- REQ-028 SHALL discard a partially sent held beat on reset mid-packet, emitting no further slices of it.
- REQ-029 SHALL raise s_axis_tready one cycle after areset deasserts.

Structure
- REQ-030 SHALL take UNITS, CORES, WORD_WIDTH and the default for M_WORDS from the shared params.v defines; R and the cnt width are local parameters.
- REQ-031 SHALL be a single module with no sub-module; the holding register and FSM are inline.

Verification
- REQ-032 Single beat: tdata words k=k (0..31), tlast=1, m_axis_tready=1 -> 4 beats on consecutive cycles carrying words 0-7, 8-15, 16-23, 24-31; tlast on the 4th only.
- REQ-033 Back-to-back: 3 beats with constant tvalid, tready=1 -> 12 output beats with no gap; s_axis_tready high only on the cycles where cnt=3.
- REQ-034 Backpressure: m_axis_tready toggling 1,0,0,1,... -> tdata, tlast and tvalid stay stable while stalled; the sequence matches REQ-032 with no loss or duplication.
- REQ-035 Reset mid-beat: areset for 1 cycle after slice 1 is sent -> tvalid=0 the next cycle; a following beat restarts at slice 0.
- REQ-036 Idle: s_axis_tvalid=0 for 10 cycles -> m_axis_tvalid=0 and tkeep=0 throughout, with s_axis_tready=1.
- REQ-037 Random: random valid/ready for 1000 beats compared against a reference model -> zero mismatches, and tlast count equals input tlast count.
